// File: rtl/sha256_round_sequencer.sv
// SHA-256 round sequencer: loads a 16-word block, then streams t, K[t], W[t]
// with a 16-entry rolling message schedule and valid/ready on both sides.
module sha256_round_sequencer #(
  parameter int ROUNDS   = 64,
  parameter bit K_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        rnd_valid,
  input  logic        rnd_ready,
  output logic [5:0]  rnd_idx,
  output logic [31:0] rnd_k,
  output logic [31:0] rnd_w,
  output logic        rnd_last,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [5:0] TLAST = 6'(ROUNDS - 1);

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic        ready_q, ready_d;
  logic        rv_q, rv_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] k_q, k_d;
  logic [31:0] w_q, w_d;
  logic        last_q, last_d;
  logic [31:0] buf_q [16];
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;

  logic        blk_fire, rnd_fire;
  logic [5:0]  tn;
  logic [3:0]  sn;
  logic [31:0] wn, kn;

  assign blk_fire = blk_valid & ready_q;
  assign rnd_fire = rv_q & rnd_ready;

  // Slot tn mod 16 still holds W[tn-16] until round tn is accepted.
  always_comb begin
    tn = t_q + 6'd1;
    sn = tn[3:0];
    wn = buf_q[sn];
    if (tn >= 6'd16) begin
      wn = ssig1(buf_q[sn - 4'd2]) + buf_q[sn - 4'd7]
         + ssig0(buf_q[sn - 4'd15]) + buf_q[sn];
    end
    kn = K_ENABLE ? KTAB[tn] : 32'd0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    ready_d = ready_q;
    rv_d    = rv_q;
    idx_d   = idx_q;
    k_d     = k_q;
    w_d     = w_q;
    last_d  = last_q;
    we      = 1'b0;
    wa      = 4'd0;
    wd      = blk_word;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      t_d     = 6'd0;
      ready_d = 1'b0;
      rv_d    = 1'b0;
      idx_d   = 6'd0;
      k_d     = 32'd0;
      w_d     = 32'd0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_d = 1'b1;
          if (blk_fire) begin
            we      = 1'b1;
            cnt_d   = 4'd1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          ready_d = 1'b1;
          if (blk_fire) begin
            we    = 1'b1;
            wa    = cnt_q;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = RUN;
              ready_d = 1'b0;
              t_d     = 6'd0;
              rv_d    = 1'b1;
              idx_d   = 6'd0;
              k_d     = K_ENABLE ? KTAB[0] : 32'd0;
              w_d     = buf_q[0];
              last_d  = (TLAST == 6'd0);
            end
          end
        end
        RUN: begin
          if (rnd_fire) begin
            we = 1'b1;
            wa = t_q[3:0];
            wd = w_q;
            if (t_q == TLAST) begin
              state_d = IDLE;
              ready_d = 1'b1;
              t_d     = 6'd0;
              rv_d    = 1'b0;
              idx_d   = 6'd0;
              k_d     = 32'd0;
              w_d     = 32'd0;
              last_d  = 1'b0;
            end else begin
              t_d    = tn;
              idx_d  = tn;
              k_d    = kn;
              w_d    = wn;
              last_d = (tn == TLAST);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      idx_q   <= 6'd0;
      k_q     <= 32'd0;
      w_q     <= 32'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      w_q     <= w_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) buf_q[wa] <= wd;
  end

  assign blk_ready = ready_q;
  assign rnd_valid = rv_q;
  assign rnd_idx   = idx_q;
  assign rnd_k     = k_q;
  assign rnd_w     = w_q;
  assign rnd_last  = last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Bench for sha256_round_sequencer: random stalls/gaps, abort, reset,
// back-to-back blocks and a 16-round K-disabled instance vs a W[] model.
module tb_sha256_round_sequencer;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        bv = 1'b0, rr = 1'b0;
  logic [31:0] bw = '0;
  logic        blk_ready, rnd_valid, rnd_last, busy;
  logic [5:0]  rnd_idx;
  logic [31:0] rnd_k, rnd_w;

  logic        abort2 = 1'b0;
  logic        bv2 = 1'b0, rr2 = 1'b0;
  logic [31:0] bw2 = '0;
  logic        br2, rv2, last2, busy2;
  logic [5:0]  idx2;
  logic [31:0] k2, w2;

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0] blkA [16];
  logic [31:0] blkB [16];
  logic [31:0] expW [64];
  logic [31:0] gotW [64];
  logic [31:0] gotK [64];
  logic        gotL [64];

  always #5 clk = ~clk;

  sha256_round_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .blk_valid(bv), .blk_ready(blk_ready), .blk_word(bw),
    .rnd_valid(rnd_valid), .rnd_ready(rr), .rnd_idx(rnd_idx),
    .rnd_k(rnd_k), .rnd_w(rnd_w), .rnd_last(rnd_last), .busy(busy)
  );

  sha256_round_sequencer #(.ROUNDS(16), .K_ENABLE(1'b0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .abort(abort2),
    .blk_valid(bv2), .blk_ready(br2), .blk_word(bw2),
    .rnd_valid(rv2), .rnd_ready(rr2), .rnd_idx(idx2),
    .rnd_k(k2), .rnd_w(w2), .rnd_last(last2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_exp();
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) expW[t] = blkA[t];
      else begin
        s0 = rotr(expW[t-15], 7) ^ rotr(expW[t-15], 18) ^ (expW[t-15] >> 3);
        s1 = rotr(expW[t-2], 17) ^ rotr(expW[t-2], 19) ^ (expW[t-2] >> 10);
        expW[t] = s1 + expW[t-7] + s0 + expW[t-16];
      end
    end
  endtask

  task automatic load_blk(input int n, input int gap, input bit imm,
                          output int ncyc);
    ncyc = 0;
    for (int i = 0; i < n; i++) begin
      bit done;
      done = 1'b0;
      while (!done && ncyc < 500) begin
        @(negedge clk);
        ncyc++;
        rr = 1'($urandom_range(1));
        bv = ($urandom_range(99) >= gap);
        bw = bv ? blkA[i] : $urandom;
        if (imm && ncyc == 1) chk("b2b_rdy", 32'(blk_ready), 32'd1);
        chk("rv_load", 32'(rnd_valid), 32'd0);
        if (bv && blk_ready) done = 1'b1;
      end
      if (!done) chk("load_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run_blk(input int stall, input int abort_at,
                         output int nacc, output int ncyc);
    int t;
    t = 0;
    ncyc = 0;
    while (t < 64 && ncyc < 2000) begin
      @(negedge clk);
      ncyc++;
      bv = 1'b0;
      rr = ($urandom_range(99) >= stall);
      chk("rv", 32'(rnd_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("brdy_run", 32'(blk_ready), 32'd0);
      chk("idx", 32'(rnd_idx), 32'(t));
      chk("k", rnd_k, KT[t]);
      chk("w", rnd_w, expW[t]);
      chk("last", 32'(rnd_last), 32'(t == 63));
      if (t == abort_at) begin
        abort = 1'b1;
        break;
      end
      if (rr) begin
        gotW[t] = rnd_w;
        gotK[t] = rnd_k;
        gotL[t] = rnd_last;
        t++;
      end
    end
    nacc = t;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    bv = 1'b0;
    rr = 1'b1;
    chk({tag, "_rv"}, 32'(rnd_valid), 32'd0);
    chk({tag, "_brdy"}, 32'(blk_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int na, nc, nl;
    int t2, c2;

    repeat (3) @(negedge clk);
    chk("rst_rv", 32'(rnd_valid), 32'd0);
    chk("rst_brdy", 32'(blk_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_w", rnd_w, 32'd0);
    rst_n = 1'b1;

    // "abc" block, full throughput
    for (int i = 0; i < 16; i++) blkA[i] = 32'd0;
    blkA[0] = 32'h61626380;
    blkA[15] = 32'h00000018;
    build_exp();
    load_blk(16, 0, 1'b0, nl);
    run_blk(0, -1, na, nc);
    chk("abc_n", 32'(na), 32'd64);
    chk("abc_cyc", 32'(nc), 32'd64);
    chk("abc_k0", gotK[0], 32'h428a2f98);
    chk("abc_w0", gotW[0], 32'h61626380);
    chk("abc_k15", gotK[15], 32'hc19bf174);
    chk("abc_w16", gotW[16], 32'h61626380);
    chk("abc_w17", gotW[17], 32'h000F0000);
    chk("abc_k63", gotK[63], 32'hc67178f2);
    chk("abc_l63", 32'(gotL[63]), 32'd1);
    idle_chk("abc_end");

    // same block with gaps and backpressure
    load_blk(16, 40, 1'b0, nl);
    run_blk(50, -1, na, nc);
    chk("stall_n", 32'(na), 32'd64);
    idle_chk("stall_end");

    // random blocks with random stalls
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) blkA[i] = $urandom;
      build_exp();
      load_blk(16, 30, 1'b0, nl);
      run_blk(30, -1, na, nc);
      chk("rnd_n", 32'(na), 32'd64);
      idle_chk("rnd_end");
    end

    // abort at t=20, then a fresh block
    load_blk(16, 0, 1'b0, nl);
    run_blk(20, 20, na, nc);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rv", 32'(rnd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) blkA[i] = $urandom;
    build_exp();
    load_blk(16, 20, 1'b0, nl);
    run_blk(20, -1, na, nc);
    chk("post_abort_n", 32'(na), 32'd64);
    chk("post_abort_w0", gotW[0], blkA[0]);
    idle_chk("post_abort_end");

    // reset after 7 loaded words
    load_blk(7, 0, 1'b0, nl);
    @(negedge clk);
    bv = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_brdy", 32'(blk_ready), 32'd0);
    chk("mid_rst_rv", 32'(rnd_valid), 32'd0);
    chk("mid_rst_idx", 32'(rnd_idx), 32'd0);
    chk("mid_rst_k", rnd_k, 32'd0);
    chk("mid_rst_w", rnd_w, 32'd0);
    chk("mid_rst_last", 32'(rnd_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) blkA[i] = $urandom;
    build_exp();
    load_blk(16, 0, 1'b0, nl);
    run_blk(0, -1, na, nc);
    chk("post_rst_w0", gotW[0], blkA[0]);
    chk("post_rst_n", 32'(na), 32'd64);
    idle_chk("post_rst_end");

    // two back-to-back blocks at full throughput
    for (int i = 0; i < 16; i++) blkA[i] = $urandom;
    build_exp();
    load_blk(16, 0, 1'b0, nl);
    chk("b2b1_load", 32'(nl), 32'd16);
    run_blk(0, -1, na, nc);
    chk("b2b1_run", 32'(nc), 32'd64);
    for (int i = 0; i < 16; i++) blkA[i] = $urandom;
    build_exp();
    load_blk(16, 0, 1'b1, nl);
    chk("b2b2_load", 32'(nl), 32'd16);
    run_blk(0, -1, na, nc);
    chk("b2b2_run", 32'(nc), 32'd64);
    idle_chk("b2b_end");

    // ROUNDS=16, K disabled instance
    for (int i = 0; i < 16; i++) blkB[i] = $urandom;
    t2 = 0;
    c2 = 0;
    while (t2 < 16 && c2 < 200) begin
      @(negedge clk);
      c2++;
      bv2 = 1'b1;
      bw2 = blkB[t2];
      if (br2) t2++;
    end
    chk("r16_loaded", 32'(t2), 32'd16);
    t2 = 0;
    while (t2 < 16 && c2 < 400) begin
      @(negedge clk);
      c2++;
      bv2 = 1'b0;
      rr2 = 1'($urandom_range(1));
      chk("r16_rv", 32'(rv2), 32'd1);
      chk("r16_idx", 32'(idx2), 32'(t2));
      chk("r16_k", k2, 32'd0);
      chk("r16_w", w2, blkB[t2]);
      chk("r16_last", 32'(last2), 32'(t2 == 15));
      if (rr2) t2++;
    end
    chk("r16_n", 32'(t2), 32'd16);
    @(negedge clk);
    chk("r16_end_rv", 32'(rv2), 32'd0);
    chk("r16_end_brdy", 32'(br2), 32'd1);
    chk("r16_end_busy", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
